// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core: sequences fetch/decode/execute/memory/writeback.
// Define MULTICYCLE_BEQ_EN to build the BEQ state; otherwise opcode 1100011 traps.
module multicycle_controller (
    input  logic       clock_i,
    input  logic       reset_ni,
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       mem_req_o,
    output logic       mem_write_o,
    output logic       adr_src_o,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic       reg_write_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] result_src_o,
    output logic [2:0] imm_src_o,
    output logic [3:0] alu_control_o,
    output logic       instr_retired_o,
    output logic       illegal_instr_o
);

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpReg   = 7'b0110011;
    localparam logic [6:0] OpImm   = 7'b0010011;
`ifdef MULTICYCLE_BEQ_EN
    localparam logic [6:0] OpBranch = 7'b1100011;
`endif

    localparam logic [3:0] AluAnd = 4'b0000;
    localparam logic [3:0] AluOr  = 4'b0001;
    localparam logic [3:0] AluAdd = 4'b0010;
    localparam logic [3:0] AluSub = 4'b0110;
    localparam logic [3:0] AluSlt = 4'b0111;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StAluWb,
        StTrap
`ifdef MULTICYCLE_BEQ_EN
        , StBeq
`endif
    } state_e;

    state_e state_q, state_d;

    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [2:0] imm_src;
    logic [3:0] alu_control;
    logic       instr_retired;

    logic       sub_en;
    logic [3:0] alu_op;
    logic       alu_legal;

    // Shared funct3 decode for register and immediate ALU ops; funct7b5 only matters for R-type.
    always_comb begin
        sub_en    = funct7b5_i & (state_q == StExecR);
        alu_op    = AluAdd;
        alu_legal = 1'b1;
        case (funct3_i)
            3'b000:  alu_op = sub_en ? AluSub : AluAdd;
            3'b111:  alu_op = AluAnd;
            3'b110:  alu_op = AluOr;
            3'b010:  alu_op = AluSlt;
            default: alu_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        mem_req       = 1'b0;
        mem_write     = 1'b0;
        adr_src       = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        result_src    = 2'b00;
        imm_src       = 3'b000;
        alu_control   = AluAdd;
        instr_retired = 1'b0;

        case (state_q)
            StFetch: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem_ready_i) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                // Branch target is computed here whether or not the instruction is a branch.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = 3'b010;
                case (opcode_i)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpReg:           state_d = StExecR;
                    OpImm:           state_d = StExecI;
`ifdef MULTICYCLE_BEQ_EN
                    OpBranch:        state_d = StBeq;
`endif
                    default:         state_d = StTrap;
                endcase
            end
            StMemAdr: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src   = (opcode_i == OpStore) ? 3'b001 : 3'b000;
                state_d   = (opcode_i == OpStore) ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready_i) begin
                    state_d = StMemWb;
                end
            end
            StMemWb: begin
                result_src    = 2'b01;
                reg_write     = 1'b1;
                instr_retired = 1'b1;
                state_d       = StFetch;
            end
            StMemWrite: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready_i) begin
                    instr_retired = 1'b1;
                    state_d       = StFetch;
                end
            end
            StExecR: begin
                alu_src_a   = 2'b10;
                alu_control = alu_op;
                state_d     = alu_legal ? StAluWb : StTrap;
            end
            StExecI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = alu_op;
                state_d     = alu_legal ? StAluWb : StTrap;
            end
            StAluWb: begin
                reg_write     = 1'b1;
                instr_retired = 1'b1;
                state_d       = StFetch;
            end
`ifdef MULTICYCLE_BEQ_EN
            StBeq: begin
                alu_src_a   = 2'b10;
                alu_control = AluSub;
                if (funct3_i == 3'b000) begin
                    pc_write      = zero_i;
                    instr_retired = 1'b1;
                    state_d       = StFetch;
                end else begin
                    state_d = StTrap;
                end
            end
`endif
            StTrap: begin
                state_d = StTrap;
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

`ifndef MULTICYCLE_BEQ_EN
    logic unused_zero;
    assign unused_zero = zero_i;
`endif

    // Reset low forces every output to 0, even though the reset state is FETCH.
    assign mem_req_o       = reset_ni & mem_req;
    assign mem_write_o     = reset_ni & mem_write;
    assign adr_src_o       = reset_ni & adr_src;
    assign ir_write_o      = reset_ni & ir_write;
    assign pc_write_o      = reset_ni & pc_write;
    assign reg_write_o     = reset_ni & reg_write;
    assign alu_src_a_o     = reset_ni ? alu_src_a : 2'b00;
    assign alu_src_b_o     = reset_ni ? alu_src_b : 2'b00;
    assign result_src_o    = reset_ni ? result_src : 2'b00;
    assign imm_src_o       = reset_ni ? imm_src : 3'b000;
    assign alu_control_o   = reset_ni ? alu_control : 4'b0000;
    assign instr_retired_o = reset_ni & instr_retired;
    assign illegal_instr_o = reset_ni & (state_q == StTrap);

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected output vectors, checked at negedge.
module tb_multicycle_controller;

    logic       clock_i = 1'b1;
    logic       reset_ni = 1'b0;
    logic [6:0] opcode_i = '0;
    logic [2:0] funct3_i = '0;
    logic       funct7b5_i = 1'b0;
    logic       zero_i = 1'b0;
    logic       mem_ready_i = 1'b0;
    logic       mem_req_o, mem_write_o, adr_src_o, ir_write_o, pc_write_o, reg_write_o;
    logic [1:0] alu_src_a_o, alu_src_b_o, result_src_o;
    logic [2:0] imm_src_o;
    logic [3:0] alu_control_o;
    logic       instr_retired_o, illegal_instr_o;

    multicycle_controller dut (
        .clock_i        (clock_i),
        .reset_ni       (reset_ni),
        .opcode_i       (opcode_i),
        .funct3_i       (funct3_i),
        .funct7b5_i     (funct7b5_i),
        .zero_i         (zero_i),
        .mem_ready_i    (mem_ready_i),
        .mem_req_o      (mem_req_o),
        .mem_write_o    (mem_write_o),
        .adr_src_o      (adr_src_o),
        .ir_write_o     (ir_write_o),
        .pc_write_o     (pc_write_o),
        .reg_write_o    (reg_write_o),
        .alu_src_a_o    (alu_src_a_o),
        .alu_src_b_o    (alu_src_b_o),
        .result_src_o   (result_src_o),
        .imm_src_o      (imm_src_o),
        .alu_control_o  (alu_control_o),
        .instr_retired_o(instr_retired_o),
        .illegal_instr_o(illegal_instr_o)
    );

    always #5 clock_i = ~clock_i;

    // {req, wr, adr, irw, pcw, rw, src_a, src_b, res, imm, alu, retired, illegal}
    logic [20:0] obs;
    assign obs = {mem_req_o, mem_write_o, adr_src_o, ir_write_o, pc_write_o, reg_write_o,
                  alu_src_a_o, alu_src_b_o, result_src_o, imm_src_o, alu_control_o,
                  instr_retired_o, illegal_instr_o};

    logic [20:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          failures = 0;

    function automatic logic [20:0] mk(input logic req, input logic wr, input logic adr,
                                       input logic irw, input logic pcw, input logic rw,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [1:0] res, input logic [2:0] imm,
                                       input logic [3:0] alu, input logic ret, input logic ill);
        return {req, wr, adr, irw, pcw, rw, sa, sb, res, imm, alu, ret, ill};
    endfunction

    function automatic logic [20:0] e_fetch(input logic rdy);
        return mk(1, 0, 0, rdy, rdy, 0, 2'b00, 2'b10, 2'b10, 3'b000, 4'b0010, 0, 0);
    endfunction
    function automatic logic [20:0] e_decode();
        return mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b010, 4'b0010, 0, 0);
    endfunction
    function automatic logic [20:0] e_memadr(input logic [2:0] imm);
        return mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, imm, 4'b0010, 0, 0);
    endfunction
    function automatic logic [20:0] e_memread();
        return mk(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0010, 0, 0);
    endfunction
    function automatic logic [20:0] e_memwb();
        return mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, 3'b000, 4'b0010, 1, 0);
    endfunction
    function automatic logic [20:0] e_memwrite(input logic rdy);
        return mk(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0010, rdy, 0);
    endfunction
    function automatic logic [20:0] e_execr(input logic [3:0] alu);
        return mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b000, alu, 0, 0);
    endfunction
    function automatic logic [20:0] e_execi(input logic [3:0] alu);
        return mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000, alu, 0, 0);
    endfunction
    function automatic logic [20:0] e_aluwb();
        return mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0010, 1, 0);
    endfunction
    function automatic logic [20:0] e_beq(input logic z);
        return mk(0, 0, 0, 0, z, 0, 2'b10, 2'b00, 2'b00, 3'b000, 4'b0110, 1, 0);
    endfunction
    function automatic logic [20:0] e_trap();
        return mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0010, 0, 1);
    endfunction

    task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    // Monitor: the DUT presents a full output vector every cycle.
    initial begin
        forever begin
            @(negedge clock_i);
            if (exp_q.size() > 0) begin
                check(name_q.pop_front(), obs, exp_q.pop_front());
            end
        end
    end

    // Called just after a rising edge; drives one cycle of inputs and queues its expectation.
    task automatic step(input string name, input logic rst, input logic rdy, input logic z,
                        input logic [20:0] e);
        reset_ni    = rst;
        mem_ready_i = rdy;
        zero_i      = z;
        exp_q.push_back(e);
        name_q.push_back(name);
        @(posedge clock_i);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        opcode_i   = op;
        funct3_i   = f3;
        funct7b5_i = f7;
    endtask

    task automatic reset_cycle();
        step("reset_hold", 0, 1, 0, '0);
    endtask

    logic [2:0] r_f3 [5] = '{3'b000, 3'b000, 3'b111, 3'b110, 3'b010};
    logic       r_f7 [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [3:0] r_alu[5] = '{4'b0110, 4'b0010, 4'b0000, 4'b0001, 4'b0111};
    logic [2:0] i_f3 [4] = '{3'b000, 3'b111, 3'b110, 3'b010};
    logic       i_f7 [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0] i_alu[4] = '{4'b0010, 4'b0000, 4'b0001, 4'b0111};

    initial begin
        #1;
        step("reset0", 0, 1, 0, '0);
        step("reset1", 0, 1, 0, '0);

        // R-type: 4 cycles each, mem_ready high in DECODE must be ignored
        for (int i = 0; i < 5; i++) begin
            set_instr(7'b0110011, r_f3[i], r_f7[i]);
            step("r_fetch", 1, 1, 0, e_fetch(1));
            step("r_decode", 1, 1, 1, e_decode());
            step("r_exec", 1, 1, 0, e_execr(r_alu[i]));
            step("r_wb", 1, 0, 0, e_aluwb());
        end

        for (int i = 0; i < 4; i++) begin
            set_instr(7'b0010011, i_f3[i], i_f7[i]);
            step("i_fetch", 1, 1, 0, e_fetch(1));
            step("i_decode", 1, 0, 0, e_decode());
            step("i_exec", 1, 0, 0, e_execi(i_alu[i]));
            step("i_wb", 1, 1, 0, e_aluwb());
        end

        // lw with two MEMREAD stall cycles: 7 cycles
        set_instr(7'b0000011, 3'b010, 1'b0);
        step("lw_fetch", 1, 1, 0, e_fetch(1));
        step("lw_decode", 1, 1, 0, e_decode());
        step("lw_memadr", 1, 1, 0, e_memadr(3'b000));
        step("lw_read_stall0", 1, 0, 0, e_memread());
        step("lw_read_stall1", 1, 0, 0, e_memread());
        step("lw_read_done", 1, 1, 0, e_memread());
        step("lw_memwb", 1, 0, 0, e_memwb());

        // sw with one FETCH stall cycle: 5 cycles
        set_instr(7'b0100011, 3'b010, 1'b0);
        step("sw_fetch_stall", 1, 0, 0, e_fetch(0));
        step("sw_fetch", 1, 1, 0, e_fetch(1));
        step("sw_decode", 1, 1, 0, e_decode());
        step("sw_memadr", 1, 1, 0, e_memadr(3'b001));
        step("sw_memwrite", 1, 1, 0, e_memwrite(1));

        // beq taken then not taken
        set_instr(7'b1100011, 3'b000, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step("beq_fetch", 1, 1, 0, e_fetch(1));
            step("beq_decode", 1, 1, 0, e_decode());
`ifdef MULTICYCLE_BEQ_EN
            step("beq_exec", 1, 1, (i == 0), e_beq(i == 0));
`else
            step("beq_trap", 1, 1, 1, e_trap());
            step("beq_trap_hold", 1, 1, 0, e_trap());
            reset_cycle();
`endif
        end

        // Illegal opcode: TRAP is sticky, never requests memory
        set_instr(7'b1111111, 3'b000, 1'b0);
        step("ill_fetch", 1, 1, 0, e_fetch(1));
        step("ill_decode", 1, 1, 0, e_decode());
        for (int i = 0; i < 20; i++) begin
            step("ill_trap", 1, i[0], i[1], e_trap());
        end
        reset_cycle();
        set_instr(7'b0110011, 3'b000, 1'b0);
        step("post_trap_fetch", 1, 1, 0, e_fetch(1));
        step("post_trap_decode", 1, 1, 0, e_decode());
        step("post_trap_exec", 1, 1, 0, e_execr(4'b0010));
        step("post_trap_wb", 1, 1, 0, e_aluwb());

        // Async reset in the middle of a stalled store
        set_instr(7'b0100011, 3'b010, 1'b0);
        step("swr_fetch", 1, 1, 0, e_fetch(1));
        step("swr_decode", 1, 1, 0, e_decode());
        step("swr_memadr", 1, 1, 0, e_memadr(3'b001));
        step("swr_stall0", 1, 0, 0, e_memwrite(0));
        mem_ready_i = 1'b0;
        exp_q.push_back(e_memwrite(0));
        name_q.push_back("swr_stall1");
        @(negedge clock_i);
        #2;
        reset_ni = 1'b0;
        #1;
        check("async_reset_outputs", obs, '0);
        @(posedge clock_i);
        #1;
        step("swr_reset_hold", 0, 1, 0, '0);
        set_instr(7'b0110011, 3'b110, 1'b0);
        step("swr_restart_fetch_stall", 1, 0, 0, e_fetch(0));
        step("swr_restart_fetch", 1, 1, 0, e_fetch(1));
        step("swr_restart_decode", 1, 1, 0, e_decode());
        step("swr_restart_exec", 1, 1, 0, e_execr(4'b0001));
        step("swr_restart_wb", 1, 1, 0, e_aluwb());

        @(negedge clock_i);
        @(negedge clock_i);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
